// File: rtl/ps2_tx_pkg.sv
// ps2_tx_pkg: scan codes, key-index lookup table, break prefix, FSM state
// type and the frame parity helper shared by the PS/2 key transmitter.
package ps2_tx_pkg;

  localparam int NUM_KEYS = 13;

  localparam logic [7:0] CODE_SPACE = 8'h29;
  localparam logic [7:0] CODE_A     = 8'h1c;
  localparam logic [7:0] CODE_S     = 8'h1b;
  localparam logic [7:0] CODE_D     = 8'h23;
  localparam logic [7:0] CODE_J     = 8'h3b;
  localparam logic [7:0] CODE_K     = 8'h42;
  localparam logic [7:0] CODE_L     = 8'h4b;
  localparam logic [7:0] CODE_X     = 8'h22;
  localparam logic [7:0] CODE_C     = 8'h21;
  localparam logic [7:0] CODE_V     = 8'h2a;
  localparam logic [7:0] CODE_B     = 8'h32;
  localparam logic [7:0] CODE_N     = 8'h31;
  localparam logic [7:0] CODE_M     = 8'h3a;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

  // key_n bit index -> scan code
  localparam logic [7:0] CODE_LUT [NUM_KEYS] = '{
    CODE_SPACE, CODE_A, CODE_S, CODE_D, CODE_J, CODE_K, CODE_L,
    CODE_X, CODE_C, CODE_V, CODE_B, CODE_N, CODE_M
  };

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GAP    = 3'd5
  } ps2_state_e;

  // Odd parity: the parity bit makes the count of ones over data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

  // Table lookup guarded against indices past the last key.
  function automatic logic [7:0] key_code(input logic [3:0] idx);
    logic [7:0] code;
    if (idx < 4'd13) begin
      code = CODE_LUT[idx];
    end else begin
      code = 8'h00;
    end
    return code;
  endfunction

endpackage

// File: rtl/ps2_key_tx_if.sv
// ps2_key_tx_if: PS/2 device-side lines plus transmitter status.
// The device drives everything (master); observers use the slave view.
interface ps2_key_tx_if;
  logic ps2_clk;
  logic ps2_data;
  logic busy;
  logic frame_done;

  modport master (output ps2_clk, output ps2_data, output busy, output frame_done);
  modport slave  (input  ps2_clk, input  ps2_data, input  busy, input  frame_done);
endinterface

// File: rtl/ps2_frame_tx.sv
// ps2_frame_tx: serializes one byte as an 11-bit PS/2 frame (start, 8 data
// LSB first, odd parity, stop). Each bit is CLK_DIV cycles with ps2_clk high
// followed by CLK_DIV cycles low; ps2_data changes at the start of a bit.
// done pulses for one cycle right after the stop bit's low phase.
module ps2_frame_tx
  import ps2_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       done
);

  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 32'd1);

  ps2_state_e  state_r;
  logic [7:0]  shift_r;
  logic        parity_r;
  logic [15:0] half_cnt_r;
  logic        low_phase_r;
  logic [3:0]  bit_cnt_r;
  logic        active_s;
  logic        half_end_s;
  logic        bit_end_s;

  assign active_s   = (state_r != IDLE);
  assign half_end_s = (half_cnt_r == HALF_LAST);
  assign bit_end_s  = active_s & half_end_s & low_phase_r;

  // Half-period timer and ps2_clk: high phase first, then low phase, per bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half_cnt_r  <= 16'd0;
      low_phase_r <= 1'b0;
      ps2_clk     <= 1'b1;
    end else if (!active_s) begin
      half_cnt_r  <= 16'd0;
      low_phase_r <= 1'b0;
      ps2_clk     <= 1'b1;
    end else if (half_end_s) begin
      half_cnt_r  <= 16'd0;
      low_phase_r <= ~low_phase_r;
      ps2_clk     <= low_phase_r;
    end else begin
      half_cnt_r  <= half_cnt_r + 16'd1;
    end
  end

  // Bit sequencer: captures the byte on start, then walks start/data/parity/stop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
      bit_cnt_r <= 4'd0;
      ps2_data  <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= START;
            shift_r   <= tx_byte;
            parity_r  <= odd_parity(tx_byte);
            bit_cnt_r <= 4'd0;
            ps2_data  <= 1'b0;
          end
        end
        START: begin
          if (bit_end_s) begin
            state_r   <= DATA;
            ps2_data  <= shift_r[0];
            shift_r   <= {1'b0, shift_r[7:1]};
            bit_cnt_r <= 4'd1;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            if (bit_cnt_r == 4'd8) begin
              state_r  <= PARITY;
              ps2_data <= parity_r;
            end else begin
              ps2_data  <= shift_r[0];
              shift_r   <= {1'b0, shift_r[7:1]};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            state_r  <= STOP;
            ps2_data <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            state_r <= IDLE;
            done    <= 1'b1;
          end
        end
        default: begin
          state_r  <= IDLE;
          ps2_data <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_tx.sv
// ps2_key_tx: 13-key PS/2 keyboard emulator. Keys are synchronized and
// edge-detected into pending make/break flags; the lowest pending key is sent
// through ps2_frame_tx, and every frame is followed by a 2*CLK_DIV idle gap.
// Optional feature macro PS2_BREAK_CODE_EN: when defined, key releases send
// F0 followed by the key code; when undefined, releases are ignored.
module ps2_key_tx
  import ps2_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2500
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  ps2_key_tx_if.master        bus
);

  localparam logic [16:0]         GAP_LAST = 17'(32'd2 * CLK_DIV - 32'd1);
  localparam logic [NUM_KEYS-1:0] KEY_ONE  = 13'd1;

  logic [NUM_KEYS-1:0] sync1_r;
  logic [NUM_KEYS-1:0] sync2_r;
  logic [NUM_KEYS-1:0] hist_r;
  logic [NUM_KEYS-1:0] make_pend_r;
  logic [NUM_KEYS-1:0] fall_s;
  logic [NUM_KEYS-1:0] req_s;
  logic [NUM_KEYS-1:0] make_clr_s;
`ifdef PS2_BREAK_CODE_EN
  logic [NUM_KEYS-1:0] brk_pend_r;
  logic [NUM_KEYS-1:0] rise_s;
  logic [NUM_KEYS-1:0] brk_clr_s;
  logic                sel_make_s;
  logic                owe_r;
  logic [3:0]          owe_idx_r;
`endif
  ps2_state_e  state_r;
  logic [16:0] gap_cnt_r;
  logic        busy_r;
  logic        gap_end_s;
  logic        any_pend_s;
  logic [3:0]  sel_idx_s;
  logic        start_s;
  logic [7:0]  tx_byte_s;
  logic        frame_clk_s;
  logic        frame_data_s;
  logic        frame_done_s;

  assign fall_s    = hist_r & ~sync2_r;
  assign gap_end_s = (state_r == GAP) && (gap_cnt_r == GAP_LAST);
`ifdef PS2_BREAK_CODE_EN
  assign rise_s     = ~hist_r & sync2_r;
  assign req_s      = make_pend_r | brk_pend_r;
  assign sel_make_s = make_pend_r[sel_idx_s];
`else
  assign req_s      = make_pend_r;
`endif

  // Two-flop synchronizer, edge history and pending flags (a new edge wins over a clear).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r     <= {NUM_KEYS{1'b1}};
      sync2_r     <= {NUM_KEYS{1'b1}};
      hist_r      <= {NUM_KEYS{1'b1}};
      make_pend_r <= {NUM_KEYS{1'b0}};
`ifdef PS2_BREAK_CODE_EN
      brk_pend_r  <= {NUM_KEYS{1'b0}};
`endif
    end else begin
      sync1_r     <= key_n;
      sync2_r     <= sync1_r;
      hist_r      <= sync2_r;
      make_pend_r <= (make_pend_r & ~make_clr_s) | fall_s;
`ifdef PS2_BREAK_CODE_EN
      brk_pend_r  <= (brk_pend_r & ~brk_clr_s) | rise_s;
`endif
    end
  end

  // Priority pick: the lowest-index key with any pending event.
  always_comb begin
    any_pend_s = 1'b0;
    sel_idx_s  = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (req_s[i]) begin
        any_pend_s = 1'b1;
        sel_idx_s  = 4'(i);
      end else begin
        any_pend_s = any_pend_s;
        sel_idx_s  = sel_idx_s;
      end
    end
  end

  // Frame launch: decides the byte for this cycle and which pending flag it consumes.
  always_comb begin
    start_s    = 1'b0;
    tx_byte_s  = 8'h00;
    make_clr_s = {NUM_KEYS{1'b0}};
`ifdef PS2_BREAK_CODE_EN
    brk_clr_s  = {NUM_KEYS{1'b0}};
`endif
    case (state_r)
      IDLE: begin
        if (any_pend_s) begin
          start_s = 1'b1;
`ifdef PS2_BREAK_CODE_EN
          if (sel_make_s) begin
            tx_byte_s  = key_code(sel_idx_s);
            make_clr_s = KEY_ONE << sel_idx_s;
          end else begin
            tx_byte_s  = BREAK_PREFIX;
            brk_clr_s  = KEY_ONE << sel_idx_s;
          end
`else
          tx_byte_s  = key_code(sel_idx_s);
          make_clr_s = KEY_ONE << sel_idx_s;
`endif
        end else begin
          start_s = 1'b0;
        end
      end
`ifdef PS2_BREAK_CODE_EN
      GAP: begin
        if (gap_end_s && owe_r) begin
          start_s   = 1'b1;
          tx_byte_s = key_code(owe_idx_r);
        end else begin
          start_s = 1'b0;
        end
      end
`endif
      default: begin
        start_s = 1'b0;
      end
    endcase
  end

  // Frame/gap sequencer; START covers the whole frame while the serializer runs it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      gap_cnt_r <= 17'd0;
      busy_r    <= 1'b0;
`ifdef PS2_BREAK_CODE_EN
      owe_r     <= 1'b0;
      owe_idx_r <= 4'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          gap_cnt_r <= 17'd0;
          if (start_s) begin
            state_r <= START;
            busy_r  <= 1'b1;
`ifdef PS2_BREAK_CODE_EN
            owe_r     <= ~sel_make_s;
            owe_idx_r <= sel_idx_s;
`endif
          end else begin
            busy_r <= 1'b0;
          end
        end
        START: begin
          if (frame_done_s) begin
            state_r   <= GAP;
            gap_cnt_r <= 17'd1;
          end
        end
        GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
`ifdef PS2_BREAK_CODE_EN
            if (owe_r) begin
              state_r <= START;
              owe_r   <= 1'b0;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
`else
            state_r <= IDLE;
            busy_r  <= 1'b0;
`endif
          end else begin
            gap_cnt_r <= gap_cnt_r + 17'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  ps2_frame_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_frame (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_s),
    .tx_byte  (tx_byte_s),
    .ps2_clk  (frame_clk_s),
    .ps2_data (frame_data_s),
    .done     (frame_done_s)
  );

  assign bus.ps2_clk    = frame_clk_s;
  assign bus.ps2_data   = frame_data_s;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_s;

endmodule

// File: doc/ps2_key_tx.md
PS2_KEY_TX -- requirements
Module: ps2_key_tx

Interface
REQ-001 SHALL have parameter: CLK_DIV, default 2500, system clocks per PS/2 half-bit period (legal range 2..65535).
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: key_n  input  13  asynchronous active-low key buttons.
  - Bit-to-code mapping: 0 space=8'h29, 1 A=8'h1c, 2 S=8'h1b, 3 D=8'h23, 4 J=8'h3b, 5 K=8'h42, 6 L=8'h4b.
  - Bit-to-code mapping: 7 X=8'h22, 8 C=8'h21, 9 V=8'h2a, 10 B=8'h32, 11 N=8'h31, 12 M=8'h3a.
REQ-005 SHALL have port: ps2_clk  output  1  PS/2 device clock, idle high.
REQ-006 SHALL have port: ps2_data  output  1  PS/2 device data, idle high.
REQ-007 SHALL have port: busy  output  1  high while any frame or inter-frame gap is in progress.
REQ-008 SHALL have port: frame_done  output  1  one-cycle pulse in the cycle after each stop bit's low phase ends.

Function
REQ-009 SHALL synchronize key_n through two flops, then edge-detect against a history register.
REQ-010 SHALL set make_pend[i] on a 1->0 synced edge and brk_pend[i] on a 0->1 synced edge. A pending bit already set is not duplicated.
REQ-011 SHALL, when idle, select the lowest index i with make_pend[i] or brk_pend[i] set.
  - If make_pend[i] is set: send the code byte and clear make_pend[i].
  - Otherwise: send 8'hF0 then the code byte, and clear brk_pend[i] at the start of the F0 frame.
REQ-012 SHALL serialize each byte as 11 bits: start 0, data bits LSB first, odd parity, stop 1.
REQ-013 SHALL drive each bit time as follows:
  - ps2_data changes at bit-time start.
  - ps2_clk is high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - One frame therefore lasts 22*CLK_DIV cycles.
REQ-014 SHALL hold ps2_clk=1 and ps2_data=1 for a gap of 2*CLK_DIV cycles after every frame, including between F0 and the code byte; busy stays high during the gap.
REQ-015 SHALL use FSM states IDLE, START, DATA, PARITY, STOP, GAP.
  - IDLE->START when any pending bit is set.
  - START->DATA after one bit time.
  - DATA->PARITY after 8 bits.
  - PARITY->STOP, then STOP->GAP.
  - GAP->START when the break code byte is still owed; otherwise GAP->IDLE.
REQ-016 SHALL take the start bit (ps2_data=0) exactly 4 cycles after key_n falls: sync 2, edge 1, select 1, assuming IDLE.
REQ-017 SHALL keep accepting edges while busy. A press and release of the same key within one frame queues make then break.
REQ-018 SHALL load the transmitted byte into a shift register at START entry. Later key_n changes do not alter a frame in flight.
REQ-019 SHALL keep the bit counter at 4 bits and the half-period counter at 16 bits, with no wrap beyond CLK_DIV-1.

Reset
REQ-020 SHALL, on rst_n low at a clock edge, set: ps2_clk=1, ps2_data=1, busy=0, frame_done=0, state IDLE, make_pend=0, brk_pend=0, sync and history registers all 1s.
REQ-021 SHALL abort any frame in flight when reset is asserted mid-frame, with lines idle high the next cycle.
REQ-022 SHALL report a key held low through reset as a new press after release of reset.

Configuration
REQ-023 SHALL implement macro PS2_BREAK_CODE_EN:
  - Defined: release events generate F0+code as in REQ-011.
  - Undefined: brk_pend is absent, releases are ignored, and only make frames are sent.

Structure
REQ-024 SHALL place in package ps2_tx_pkg: the 13 scan-code constants, the index-to-code lookup table, the BREAK_PREFIX=8'hF0 constant, and the FSM state typedef.
REQ-025 SHALL contain one sub-module, ps2_frame_tx.
  - Inputs: byte plus start strobe.
  - Outputs: ps2_clk, ps2_data, done.
  - Covers the START..STOP bit timing.
  - The top level owns the pending logic, selection and GAP.

Verification (CLK_DIV=4)
REQ-026 SHALL test: key_n[1] falls → after 4 cycles, frame 0,0,0,1,1,1,0,0,0,parity 0,stop 1 (8'h1c), 88 cycles long; frame_done pulses once.
REQ-027 SHALL test: key_n[1] rises with PS2_BREAK_CODE_EN defined → frame 8'hF0 (parity 1), gap of 8 cycles, then frame 8'h1c; busy is continuously high.
REQ-028 SHALL test: key_n[12] and key_n[0] fall in the same cycle → 8'h29 is sent first, then 8'h3a.
REQ-029 SHALL test: key_n[4] pressed and released during an 8'h29 frame → after it, 8'h3b, then F0, then 8'h3b.
REQ-030 SHALL test: rst_n low at bit 5 of a frame → next cycle ps2_clk=1, ps2_data=1, busy=0, and nothing is sent afterwards.
REQ-031 SHALL test: PS2_BREAK_CODE_EN undefined, key_n[7] press then release → only the 8'h22 frame is sent.
